// File: rtl/pc_fetch_ctrl.sv
// Next-PC sequencer: sequential fetch, branch/trap/mret redirects, I-cache miss and hazard stalls.
// Optional MISALIGN_TRAP_EN: misaligned branch/mret targets divert to trap_vec and pulse misalign_exc.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter int          PC_W      = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [PC_W-1:0] pc_addr,
  input  logic            icache_ready,
  output logic            icache_req,
  input  logic            stall_in,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_target,
  input  logic            trap_req,
  input  logic [PC_W-1:0] trap_vec,
  input  logic            mret_req,
  input  logic [PC_W-1:0] mepc,
  output logic [PC_W-1:0] next_pc,
  output logic            halt,
  output logic            flush,
  output logic            misalign_exc
);

  typedef enum logic [1:0] {BOOT, FETCH, MISS} state_t;

  state_t          state, state_nx;
  logic            boot_ld, boot_nx;
  logic            pend_valid;
  logic [PC_W-1:0] pend_target;
  logic [1:0]      pend_prio;

  logic [PC_W-1:0] raw_tgt, live_tgt, mrg_tgt, seq_pc;
  logic [1:0]      live_prio;
  logic            live_vld, live_mis, live_wins, mrg_vld;
  logic            accept, pend_set, pend_clr;

  assign seq_pc     = pc_addr + 32'd4;
  assign icache_req = (state != BOOT);

  // Resolve the live redirect: priority 3=trap, 2=mret, 1=branch, 0=none.
  always_comb begin
    raw_tgt   = br_target;
    live_prio = 2'd0;
    if (trap_req) begin
      raw_tgt   = trap_vec;
      live_prio = 2'd3;
    end else if (mret_req) begin
      raw_tgt   = mepc;
      live_prio = 2'd2;
    end else if (br_taken) begin
      raw_tgt   = br_target;
      live_prio = 2'd1;
    end
    live_vld = (live_prio != 2'd0);
    live_mis = live_vld && !trap_req && (raw_tgt[1:0] != 2'b00);
    live_tgt = raw_tgt;
`ifdef MISALIGN_TRAP_EN
    if (live_mis) begin
      live_tgt  = trap_vec;
      live_prio = 2'd3;
    end
`else
    if (live_mis) live_tgt = {raw_tgt[PC_W-1:2], 2'b00};
`endif
  end

  // Equal priority lets the newer (live) redirect replace the buffered one.
  assign live_wins = live_vld && (!pend_valid || (live_prio >= pend_prio));
  assign mrg_vld   = live_vld || pend_valid;
  assign mrg_tgt   = live_wins ? live_tgt : pend_target;

  always_comb begin
    halt     = 1'b1;
    next_pc  = pc_addr;
    state_nx = state;
    boot_nx  = boot_ld;
    accept   = 1'b0;
    pend_set = 1'b0;
    pend_clr = 1'b0;
    case (state)
      BOOT: begin
        next_pc = RESET_VEC;
        halt    = !boot_ld;
        boot_nx = 1'b1;
        if (boot_ld) state_nx = FETCH;
      end
      FETCH: begin
        if (live_vld) begin
          halt    = 1'b0;
          next_pc = live_tgt;
          accept  = 1'b1;
        end else if (!icache_ready) begin
          state_nx = MISS;
        end else if (!stall_in) begin
          halt    = 1'b0;
          next_pc = seq_pc;
        end
      end
      MISS: begin
        if (icache_ready) begin
          state_nx = FETCH;
          if (mrg_vld) begin
            halt     = 1'b0;
            next_pc  = mrg_tgt;
            accept   = 1'b1;
            pend_clr = 1'b1;
          end else if (!stall_in) begin
            halt    = 1'b0;
            next_pc = seq_pc;
          end
        end else if (live_vld) begin
          pend_set = 1'b1;
          accept   = 1'b1;
        end
      end
      default: state_nx = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= BOOT;
      boot_ld     <= 1'b0;
      pend_valid  <= 1'b0;
      pend_target <= '0;
      pend_prio   <= 2'd0;
      flush       <= 1'b0;
    end else begin
      state   <= state_nx;
      boot_ld <= boot_nx;
      flush   <= accept;
      if (pend_clr) begin
        pend_valid <= 1'b0;
      end else if (pend_set && live_wins) begin
        pend_valid  <= 1'b1;
        pend_target <= live_tgt;
        pend_prio   <= live_prio;
      end
    end
  end

`ifdef MISALIGN_TRAP_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) misalign_exc <= 1'b0;
    else       misalign_exc <= live_mis && (state != BOOT);
  end
`else
  assign misalign_exc = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboard bench for pc_fetch_ctrl: directed per-cycle vectors push expectations, a negedge monitor checks them.
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc_addr = 32'h0;
  logic        icache_ready = 1'b0;
  logic        icache_req;
  logic        stall_in = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = 32'h0;
  logic        trap_req = 1'b0;
  logic [31:0] trap_vec = 32'h0000_0080;
  logic        mret_req = 1'b0;
  logic [31:0] mepc = 32'h0000_0300;
  logic [31:0] next_pc;
  logic        halt;
  logic        flush;
  logic        misalign_exc;

  always #5 clk = ~clk;

  pc_fetch_ctrl #(.RESET_VEC(32'h0000_0000), .PC_W(32)) dut (
    .clk(clk), .reset(reset), .pc_addr(pc_addr), .icache_ready(icache_ready),
    .icache_req(icache_req), .stall_in(stall_in), .br_taken(br_taken),
    .br_target(br_target), .trap_req(trap_req), .trap_vec(trap_vec),
    .mret_req(mret_req), .mepc(mepc), .next_pc(next_pc), .halt(halt),
    .flush(flush), .misalign_exc(misalign_exc)
  );

`ifdef MISALIGN_TRAP_EN
  localparam logic [31:0] T6_PC  = 32'h0000_0080;
  localparam logic        T6_MIS = 1'b1;
`else
  localparam logic [31:0] T6_PC  = 32'h0000_0200;
  localparam logic        T6_MIS = 1'b0;
`endif

  typedef struct {
    string       name;
    logic        halt;
    logic [31:0] pc;
    logic        flush;
    logic        mis;
    logic        req;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // One cycle of stimulus; red = {trap, mret, br}.
  task automatic cyc(input string nm, input logic r, input logic [31:0] pc,
                     input logic rdy, input logic stl, input logic [2:0] red,
                     input logic [31:0] brt, input logic eh, input logic [31:0] epc,
                     input logic ef, input logic em, input logic eq);
    exp_t e;
    @(posedge clk);
    #1;
    reset        = r;
    pc_addr      = pc;
    icache_ready = rdy;
    stall_in     = stl;
    trap_req     = red[2];
    mret_req     = red[1];
    br_taken     = red[0];
    br_target    = brt;
    e.name = nm; e.halt = eh; e.pc = epc; e.flush = ef; e.mis = em; e.req = eq;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if ({halt, next_pc, flush, misalign_exc, icache_req} !== {e.halt, e.pc, e.flush, e.mis, e.req}) begin
        errors++;
        $display("FAIL %s: got halt=%b next_pc=%h flush=%b mis=%b req=%b, want halt=%b next_pc=%h flush=%b mis=%b req=%b",
                 e.name, halt, next_pc, flush, misalign_exc, icache_req,
                 e.halt, e.pc, e.flush, e.mis, e.req);
      end
    end
  end

  initial begin
    //   name          rst pc            rdy stl red     brt           halt next_pc       fl  mis        req
    cyc("rst0",        1, 32'h1234,      1, 0, 3'b000, 32'h0,         1, 32'h0,         0, 0,         0);
    cyc("rst1",        1, 32'h1234,      1, 0, 3'b000, 32'h0,         1, 32'h0,         0, 0,         0);
    cyc("boot_hold",   0, 32'h1234,      1, 0, 3'b000, 32'h0,         1, 32'h0,         0, 0,         0);
    cyc("boot_load",   0, 32'h1234,      1, 0, 3'b000, 32'h0,         0, 32'h0,         0, 0,         0);
    cyc("seq0",        0, 32'h0,         1, 0, 3'b000, 32'h0,         0, 32'h4,         0, 0,         1);
    cyc("seq4",        0, 32'h4,         1, 0, 3'b000, 32'h0,         0, 32'h8,         0, 0,         1);
    cyc("seq8",        0, 32'h8,         1, 0, 3'b000, 32'h0,         0, 32'hC,         0, 0,         1);
    cyc("miss1",       0, 32'h100,       0, 0, 3'b000, 32'h0,         1, 32'h100,       0, 0,         1);
    cyc("miss2",       0, 32'h100,       0, 0, 3'b000, 32'h0,         1, 32'h100,       0, 0,         1);
    cyc("miss3",       0, 32'h100,       0, 0, 3'b000, 32'h0,         1, 32'h100,       0, 0,         1);
    cyc("refill",      0, 32'h100,       1, 0, 3'b000, 32'h0,         0, 32'h104,       0, 0,         1);
    cyc("m3_miss",     0, 32'h104,       0, 0, 3'b000, 32'h0,         1, 32'h104,       0, 0,         1);
    cyc("m3_br",       0, 32'h104,       0, 0, 3'b001, 32'h200,       1, 32'h104,       0, 0,         1);
    cyc("m3_wait",     0, 32'h104,       0, 0, 3'b000, 32'h0,         1, 32'h104,       1, 0,         1);
    cyc("m3_trap",     0, 32'h104,       0, 0, 3'b100, 32'h0,         1, 32'h104,       0, 0,         1);
    cyc("m3_wait2",    0, 32'h104,       0, 0, 3'b000, 32'h0,         1, 32'h104,       1, 0,         1);
    cyc("m3_ready",    0, 32'h104,       1, 0, 3'b000, 32'h0,         0, 32'h80,        0, 0,         1);
    cyc("m3_after",    0, 32'h80,        1, 0, 3'b000, 32'h0,         0, 32'h84,        1, 0,         1);
    cyc("eq_miss",     0, 32'h84,        0, 0, 3'b000, 32'h0,         1, 32'h84,        0, 0,         1);
    cyc("eq_br1",      0, 32'h84,        0, 0, 3'b001, 32'h200,       1, 32'h84,        0, 0,         1);
    cyc("eq_br2",      0, 32'h84,        0, 0, 3'b001, 32'h240,       1, 32'h84,        1, 0,         1);
    cyc("eq_wait",     0, 32'h84,        0, 0, 3'b000, 32'h0,         1, 32'h84,        1, 0,         1);
    cyc("eq_ready",    0, 32'h84,        1, 0, 3'b000, 32'h0,         0, 32'h240,       0, 0,         1);
    cyc("eq_after",    0, 32'h240,       1, 0, 3'b000, 32'h0,         0, 32'h244,       1, 0,         1);
    cyc("sc_miss",     0, 32'h244,       0, 0, 3'b000, 32'h0,         1, 32'h244,       0, 0,         1);
    cyc("sc_br",       0, 32'h244,       0, 0, 3'b001, 32'h200,       1, 32'h244,       0, 0,         1);
    cyc("sc_mret_rdy", 0, 32'h244,       1, 0, 3'b010, 32'h0,         0, 32'h300,       1, 0,         1);
    cyc("sc_stall",    0, 32'h300,       1, 1, 3'b000, 32'h0,         1, 32'h300,       1, 0,         1);
    cyc("sc_go",       0, 32'h300,       1, 0, 3'b000, 32'h0,         0, 32'h304,       0, 0,         1);
    cyc("t4_all",      0, 32'h304,       0, 1, 3'b111, 32'h200,       0, 32'h80,        0, 0,         1);
    cyc("t4_after",    0, 32'h80,        1, 0, 3'b000, 32'h0,         0, 32'h84,        1, 0,         1);
    cyc("sm_miss",     0, 32'h84,        0, 0, 3'b000, 32'h0,         1, 32'h84,        0, 0,         1);
    cyc("sm_stall",    0, 32'h84,        1, 1, 3'b000, 32'h0,         1, 32'h84,        0, 0,         1);
    cyc("sm_go",       0, 32'h84,        1, 0, 3'b000, 32'h0,         0, 32'h88,        0, 0,         1);
    cyc("wrap",        0, 32'hFFFF_FFFC, 1, 0, 3'b000, 32'h0,         0, 32'h0,         0, 0,         1);
    cyc("t6_mis",      0, 32'h0,         1, 0, 3'b001, 32'h202,       0, T6_PC,         0, 0,         1);
    cyc("t6_after",    0, T6_PC,         1, 0, 3'b000, 32'h0,         0, T6_PC + 32'd4, 1, T6_MIS,    1);
    cyc("rr_miss",     0, 32'h204,       0, 0, 3'b000, 32'h0,         1, 32'h204,       0, 0,         1);
    cyc("rr_br",       0, 32'h204,       0, 0, 3'b001, 32'h300,       1, 32'h204,       0, 0,         1);
    cyc("rr_rst",      1, 32'h204,       0, 0, 3'b000, 32'h0,         1, 32'h0,         0, 0,         0);
    cyc("rr_rst2",     1, 32'h204,       0, 0, 3'b000, 32'h0,         1, 32'h0,         0, 0,         0);
    cyc("rr_hold",     0, 32'h204,       1, 0, 3'b000, 32'h0,         1, 32'h0,         0, 0,         0);
    cyc("rr_load",     0, 32'h204,       1, 0, 3'b000, 32'h0,         0, 32'h0,         0, 0,         0);
    cyc("rr_seq",      0, 32'h0,         1, 0, 3'b000, 32'h0,         0, 32'h4,         0, 0,         1);
    cyc("rr_miss2",    0, 32'h4,         0, 0, 3'b000, 32'h0,         1, 32'h4,         0, 0,         1);
    cyc("rr_refill",   0, 32'h4,         1, 0, 3'b000, 32'h0,         0, 32'h8,         0, 0,         1);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
